bus_slave_regfile: RTL and testbench

BUS_SLAVE_REGFILE -- requirements
Module: bus_slave_regfile

---
 rtl/bus_slave_regfile.sv | 152 +++++++++++++++
 tb/tb_bus_slave_regfile.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_regfile.sv
// rtl/bus_slave_regfile.sv - wait-state register file slave with a constant ID register at index 0
// Optional error response: define BUS_SLAVE_REGFILE_ERR_EN to drive err on bad accesses.
module bus_slave_regfile #(
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 32,
   parameter int                NUM_REGS    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0010,
   parameter int                WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] write_data,
   output logic              ready,
   output logic [DATA_W-1:0] read_data,
   output logic              err
);

   localparam int                IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [DATA_W-1:0] ID_VALUE  = DATA_W'(32'h0B05_0001);
   localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_rd;
   logic              r_wr;
   logic [3:0]        r_cnt;
   logic [DATA_W-1:0] r_regs [NUM_REGS];

   logic              w_capture;
   logic [ADDR_W-1:0] w_offset;
   logic [ADDR_W-1:0] w_word;
   logic [IDX_W-1:0]  w_idx;
   logic              w_in_range;
   logic              w_wr_ok;
   logic              w_rd_ok;

   assign w_capture  = valid && (read || write);

   // Decode works on the captured address so late bus changes cannot disturb it.
   assign w_offset   = r_addr - BASE_ADDR;
   assign w_word     = w_offset >> 2;
   assign w_idx      = w_word[IDX_W-1:0];
   assign w_in_range = (w_offset[1:0] == 2'b00) && (w_word < ADDR_W'(NUM_REGS));

   // Index 0 is the read-only ID register, so writes to it are quietly discarded.
   assign w_wr_ok    = r_wr && !r_rd && w_in_range && (w_idx != '0);
   assign w_rd_ok    = r_rd && !r_wr && w_in_range;

`ifdef BUS_SLAVE_REGFILE_ERR_EN
   logic w_bad;
   assign w_bad = (r_rd && r_wr) || !w_in_range;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: optional wait phase, abort when the master withdraws valid.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_capture) begin
               w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            end
         end
         ST_WAIT: begin
            if (!valid) begin
               w_next = ST_IDLE;
            end else if (r_cnt <= 4'd1) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Request capture in IDLE and wait-state down-counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_cnt   <= 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_capture) begin
                  r_addr  <= addr;
                  r_wdata <= write_data;
                  r_rd    <= read;
                  r_wr    <= write;
                  r_cnt   <= WAIT_LOAD;
               end
            end
            ST_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: r_cnt <= 4'd0;
         endcase
      end
   end

   // Register storage: a write commits on the edge that closes the response cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if ((r_state == ST_RESP) && w_wr_ok) begin
         r_regs[w_idx] <= r_wdata;
      end
   end

   // Response outputs are valid only in RESP and zero everywhere else.
   always_comb begin
      ready     = 1'b0;
      read_data = '0;
      err       = 1'b0;
      if (r_state == ST_RESP) begin
         ready = 1'b1;
         if (w_rd_ok) begin
            read_data = (w_idx == '0) ? ID_VALUE : r_regs[w_idx];
         end
`ifdef BUS_SLAVE_REGFILE_ERR_EN
         err = w_bad;
`endif
      end
   end

endmodule

// File: tb/tb_bus_slave_regfile.sv
// tb/tb_bus_slave_regfile.sv - randomized reference-model bench for bus_slave_regfile (unit 0: one wait state, unit 1: none)
module tb_bus_slave_regfile;

`ifdef BUS_SLAVE_REGFILE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        valid   [2];
   logic        rd_i    [2];
   logic        wr_i    [2];
   logic [15:0] addr_i  [2];
   logic [31:0] wdata_i [2];
   logic        ready_o [2];
   logic [31:0] rdata_o [2];
   logic        err_o   [2];

   logic [31:0] mdl [2][16];
   int          last_rdy [2];
   bit          chained  [2];
   int          cyc;
   int          n_checks;
   int          n_errors;

   bus_slave_regfile #(.WAIT_CYCLES(1)) u_dut0 (
      .clk(clk), .reset(reset), .valid(valid[0]), .read(rd_i[0]), .write(wr_i[0]),
      .addr(addr_i[0]), .write_data(wdata_i[0]), .ready(ready_o[0]),
      .read_data(rdata_o[0]), .err(err_o[0])
   );

   bus_slave_regfile #(.WAIT_CYCLES(0)) u_dut1 (
      .clk(clk), .reset(reset), .valid(valid[1]), .read(rd_i[1]), .write(wr_i[1]),
      .addr(addr_i[1]), .write_data(wdata_i[1]), .ready(ready_o[1]),
      .read_data(rdata_o[1]), .err(err_o[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int wc(input int u);
      return (u == 0) ? 1 : 0;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 16; i++) mdl[u][i] = 32'h0;
         chained[u] = 1'b0;
      end
   endtask

   task automatic model(input int u, input bit rd, input bit wr, input logic [15:0] a,
                        input logic [31:0] wd, output logic [31:0] ed, output logic ee);
      logic [15:0] off;
      int          idx;
      bit          inr;
      off = a - 16'h0010;
      idx = int'(off) / 4;
      inr = (int'(off) % 4 == 0) && (idx < 16);
      ed  = 32'h0;
      ee  = ERR_EN && ((rd && wr) || !inr);
      if (rd && !wr && inr) ed = (idx == 0) ? 32'h0B05_0001 : mdl[u][idx];
      if (wr && !rd && inr && idx != 0) mdl[u][idx] = wd;
   endtask

   task automatic xfer(input int u, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [31:0] wd, input bit keep, output logic [31:0] got);
      logic [31:0] ed;
      logic        ee;
      int          lat;
      bit          seen;
      model(u, rd, wr, a, wd, ed, ee);
      valid[u] = 1'b1; rd_i[u] = rd; wr_i[u] = wr; addr_i[u] = a; wdata_i[u] = wd;
      got = 32'h0; lat = 0; seen = 1'b0;
      @(posedge clk);
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         if (ready_o[u]) begin
            seen = 1'b1;
            got  = rdata_o[u];
            check("rdata", rdata_o[u], ed);
            check("err", err_o[u], ee);
            check("latency", lat, wc(u) + 1);
            if (chained[u]) check("b2b_period", cyc - last_rdy[u], wc(u) + 2);
            last_rdy[u] = cyc;
         end else begin
            check("rdata_outside_resp", rdata_o[u], 0);
            check("err_outside_resp", err_o[u], 0);
            @(posedge clk);
         end
      end
      if (!seen) check("ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      check("ready_one_cycle", ready_o[u], 0);
      chained[u] = keep && seen;
      if (!keep) valid[u] = 1'b0;
   endtask

   initial begin
      logic [31:0] got;
      logic [15:0] a;
      bit          rd, wr, keep, seen;
      int          r;

      clk = 1'b0; reset = 1'b0; cyc = 0; n_checks = 0; n_errors = 0;
      for (int u = 0; u < 2; u++) begin
         valid[u] = 1'b0; rd_i[u] = 1'b0; wr_i[u] = 1'b0; addr_i[u] = '0; wdata_i[u] = '0;
         last_rdy[u] = 0;
      end
      clear_model();

      repeat (2) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check("reset_ready", ready_o[u], 0);
         check("reset_rdata", rdata_o[u], 0);
         check("reset_err", err_o[u], 0);
      end
      reset = 1'b1;

      // Basic write/read-back and the ID register.
      xfer(0, 0, 1, 16'h0014, 32'hDEAD_BEEF, 0, got);
      xfer(0, 1, 0, 16'h0014, 32'h0, 0, got);
      check("readback_0x14", got, 32'hDEAD_BEEF);
      xfer(0, 1, 0, 16'h0010, 32'h0, 0, got);
      check("id_read", got, 32'h0B05_0001);
      xfer(0, 0, 1, 16'h0010, 32'h1234, 0, got);
      xfer(0, 1, 0, 16'h0010, 32'h0, 0, got);
      check("id_after_write", got, 32'h0B05_0001);

      // Misaligned and out-of-range reads.
      xfer(0, 1, 0, 16'h0012, 32'h0, 0, got);
      check("misaligned_data", got, 0);
      xfer(0, 1, 0, 16'h0050, 32'h0, 0, got);
      check("out_of_range_data", got, 0);
      xfer(0, 1, 1, 16'h0014, 32'h0, 0, got);
      check("illegal_op_data", got, 0);

      // Master withdraws valid during the wait phase.
      valid[0] = 1'b1; rd_i[0] = 1'b0; wr_i[0] = 1'b1; addr_i[0] = 16'h0018; wdata_i[0] = 32'h55AA_55AA;
      @(posedge clk);
      @(negedge clk);
      check("abort_ready_in_wait", ready_o[0], 0);
      valid[0] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("abort_no_ready", ready_o[0], 0);
      end
      xfer(0, 1, 0, 16'h0018, 32'h0, 0, got);
      check("abort_no_write", got, 0);

      // Reset in the response cycle of a write.
      valid[0] = 1'b1; rd_i[0] = 1'b0; wr_i[0] = 1'b1; addr_i[0] = 16'h001C; wdata_i[0] = 32'hCAFE_F00D;
      @(posedge clk);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (ready_o[0]) seen = 1'b1;
      end
      check("reached_resp", seen, 1);
      #2 reset = 1'b0;
      #1;
      check("reset_drops_ready", ready_o[0], 0);
      check("reset_clears_rdata", rdata_o[0], 0);
      valid[0] = 1'b0;
      clear_model();
      @(negedge clk);
      reset = 1'b1;
      xfer(0, 1, 0, 16'h001C, 32'h0, 0, got);
      check("no_partial_write", got, 0);

      // Zero wait states, back-to-back writes then reads.
      xfer(1, 0, 1, 16'h0014, 32'h1111_2222, 1, got);
      xfer(1, 0, 1, 16'h0018, 32'h3333_4444, 1, got);
      xfer(1, 1, 0, 16'h0014, 32'h0, 1, got);
      check("b2b_read_0x14", got, 32'h1111_2222);
      xfer(1, 1, 0, 16'h0018, 32'h0, 0, got);
      check("b2b_read_0x18", got, 32'h3333_4444);

      // Randomized traffic on each unit against the reference model.
      for (int u = 0; u < 2; u++) begin
         for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      a = 16'h0010 + 16'(4 * $urandom_range(0, 17));
            else if (r < 8) a = 16'h0010 + 16'($urandom_range(0, 70));
            else            a = 16'($urandom);
            r  = $urandom_range(0, 9);
            rd = (r < 5) || (r == 9);
            wr = (r >= 5);
            keep = (n != 149) && ($urandom_range(0, 1) == 1);
            xfer(u, rd, wr, a, $urandom, keep, got);
         end
      end

      // Final sweep of every register on both units.
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 16; i++) begin
            xfer(u, 1, 0, 16'h0010 + 16'(4 * i), 32'h0, 0, got);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
